execute_muldiv: RTL and testbench

EXECUTE_MULDIV -- requirements
Module: execute_muldiv

---
 rtl/execute_muldiv.sv | 203 ++++++++++++++++++++
 tb/tb_execute_muldiv.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv.sv
// execute_muldiv: EX stage with forwarding, ALU and iterative HI/LO multiply/divide unit
module execute_muldiv #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_SH   = 5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_RA,
    input  logic [NB_DATA-1:0] i_RB,
    input  logic [NB_DATA-1:0] i_inmediato,
    input  logic [NB_REG-1:0]  i_rt,
    input  logic [NB_REG-1:0]  i_rd,
    input  logic [5:0]         i_funct,
    input  logic [5:0]         i_opcode,
    input  logic [NB_SH-1:0]   i_shamt,
    input  logic [3:0]         i_ctrl,
    input  logic               i_EX_alu_src,
    input  logic               i_EX_reg_dst,
    input  logic [1:0]         i_EX_alu_op,
    input  logic [1:0]         i_corto_rs,
    input  logic [1:0]         i_corto_rt,
    input  logic [NB_DATA-1:0] i_input_ALU_MEM,
    input  logic [NB_DATA-1:0] i_output_WB,
    output logic               o_stall,
    output logic               o_busy,
    output logic [3:0]         o_ctrl,
    output logic [NB_REG-1:0]  o_write_reg,
    output logic [NB_DATA-1:0] o_data_to_write_in_MEM,
    output logic [NB_DATA-1:0] o_ALU_result
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    localparam int NB_CNT = NB_SH + 1;

    state_t state_q, state_d;
    logic [NB_CNT-1:0] cnt_q, cnt_d;
    logic [NB_DATA-1:0] acc_q, acc_d, quo_q, quo_d, opb_q, opb_d, hi_q, hi_d, lo_q, lo_d;
    logic is_div_q, is_div_d, neg_q, neg_d, rem_neg_q, rem_neg_d, dz_q, dz_d, busy_q, busy_d;
    logic [3:0] ctrl_q, ctrl_d;
    logic [NB_REG-1:0] wreg_q, wreg_d;
    logic [NB_DATA-1:0] wdata_q, wdata_d, res_q, res_d;
    logic [NB_DATA-1:0] op_a, rt_val, op_b, alu_res, diff, q_fix, r_fix;
    logic [NB_DATA:0] sum, shl;
    logic [2*NB_DATA-1:0] prod;
    logic md_op, accept, start, sgn, a_neg, b_neg, ge;

    always_comb begin
        op_a = i_corto_rs == 2'b00 ? i_RA : i_corto_rs == 2'b01 ? i_output_WB :
               i_corto_rs == 2'b10 ? i_input_ALU_MEM : '0;
        rt_val = i_corto_rt == 2'b00 ? i_RB : i_corto_rt == 2'b01 ? i_output_WB :
                 i_corto_rt == 2'b10 ? i_input_ALU_MEM : '0;
        op_b = i_EX_alu_src ? i_inmediato : rt_val;
    end

    always_comb begin
        alu_res = '0;
        case (i_EX_alu_op)
            2'b00: alu_res = op_a + op_b;
            2'b10: case (i_funct)
                6'h00: alu_res = op_b << i_shamt;
                6'h02: alu_res = op_b >> i_shamt;
                6'h03: alu_res = $signed(op_b) >>> i_shamt;
                6'h04: alu_res = op_a << op_b[NB_SH-1:0];
                6'h06: alu_res = op_a >> op_b[NB_SH-1:0];
                6'h07: alu_res = $signed(op_a) >>> op_b[NB_SH-1:0];
                6'h10: alu_res = hi_q;
                6'h12: alu_res = lo_q;
                6'h20, 6'h21: alu_res = op_a + op_b;
                6'h22, 6'h23: alu_res = op_a - op_b;
                6'h24: alu_res = op_a & op_b;
                6'h25: alu_res = op_a | op_b;
                6'h26: alu_res = op_a ^ op_b;
                6'h27: alu_res = ~(op_a | op_b);
                6'h2A: alu_res = NB_DATA'($signed(op_a) < $signed(op_b));
                6'h2B: alu_res = NB_DATA'(op_a < op_b);
                default: alu_res = '0;
            endcase
            2'b11: case (i_opcode)
                6'h08, 6'h09: alu_res = op_a + op_b;
                6'h0A: alu_res = NB_DATA'($signed(op_a) < $signed(op_b));
                6'h0B: alu_res = NB_DATA'(op_a < op_b);
                6'h0C: alu_res = op_a & op_b;
                6'h0D: alu_res = op_a | op_b;
                6'h0E: alu_res = op_a ^ op_b;
                6'h0F: alu_res = i_inmediato << (NB_DATA / 2);
                default: alu_res = '0;
            endcase
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        md_op = i_EX_alu_op == 2'b10 && (i_funct[5:2] == 4'b0100 || i_funct[5:2] == 4'b0110);
        o_stall = i_valid && busy_q && md_op;
        accept = i_valid && !o_stall;
        start = accept && md_op && i_funct[5:2] == 4'b0110;
        sgn = !i_funct[0];
        a_neg = sgn && op_a[NB_DATA-1];
        b_neg = sgn && op_b[NB_DATA-1];
        sum = {1'b0, acc_q} + (quo_q[0] ? {1'b0, opb_q} : '0);
        shl = {acc_q, quo_q[NB_DATA-1]};
        ge = shl >= {1'b0, opb_q};
        diff = shl[NB_DATA-1:0] - opb_q;
        prod = neg_q ? -{acc_q, quo_q} : {acc_q, quo_q};
        q_fix = dz_q ? '1 : neg_q ? -quo_q : quo_q;
        r_fix = rem_neg_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        quo_d = quo_q;
        opb_d = opb_q;
        is_div_d = is_div_q;
        neg_d = neg_q;
        rem_neg_d = rem_neg_q;
        dz_d = dz_q;
        hi_d = hi_q;
        lo_d = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d = NB_CNT'(NB_DATA);
                    acc_d = '0;
                    quo_d = a_neg ? -op_a : op_a;
                    opb_d = b_neg ? -op_b : op_b;
                    is_div_d = i_funct[1];
                    neg_d = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    dz_d = i_funct[1] && op_b == '0;
                end else if (accept && md_op && i_funct == 6'h11) begin
                    hi_d = op_a;
                end else if (accept && md_op && i_funct == 6'h13) begin
                    lo_d = op_a;
                end
            end
            RUN: begin
                cnt_d = cnt_q - NB_CNT'(1);
                state_d = cnt_q == NB_CNT'(1) ? FIX : RUN;
                acc_d = is_div_q ? (ge ? diff : shl[NB_DATA-1:0]) : sum[NB_DATA:1];
                quo_d = is_div_q ? {quo_q[NB_DATA-2:0], ge} : {sum[0], quo_q[NB_DATA-1:1]};
            end
            FIX: begin
                state_d = IDLE;
                hi_d = is_div_q ? r_fix : prod[2*NB_DATA-1:NB_DATA];
                lo_d = is_div_q ? q_fix : prod[NB_DATA-1:0];
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
        ctrl_d = accept ? i_ctrl : '0;
        wreg_d = accept ? (i_EX_reg_dst ? i_rd : i_rt) : '0;
        wdata_d = accept ? rt_val : '0;
        res_d = accept ? alu_res : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            acc_q <= '0;
            quo_q <= '0;
            opb_q <= '0;
            is_div_q <= 1'b0;
            neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q <= 1'b0;
            hi_q <= '0;
            lo_q <= '0;
            busy_q <= 1'b0;
            ctrl_q <= '0;
            wreg_q <= '0;
            wdata_q <= '0;
            res_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            quo_q <= quo_d;
            opb_q <= opb_d;
            is_div_q <= is_div_d;
            neg_q <= neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q <= dz_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
            busy_q <= busy_d;
            ctrl_q <= ctrl_d;
            wreg_q <= wreg_d;
            wdata_q <= wdata_d;
            res_q <= res_d;
        end
    end

    assign o_busy = busy_q;
    assign o_ctrl = ctrl_q;
    assign o_write_reg = wreg_q;
    assign o_data_to_write_in_MEM = wdata_q;
    assign o_ALU_result = res_q;
endmodule

// File: tb/tb_execute_muldiv.sv
// tb_execute_muldiv: directed and randomized checks of execute_muldiv against an arithmetic reference model
module tb_execute_muldiv;
    localparam int N = 32;
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst, valid, alu_src, reg_dst;
    logic [31:0] ra, rb, imm, fw_mem, fw_wb;
    logic [4:0] rt, rd, shamt;
    logic [5:0] funct, opcode;
    logic [3:0] ctrl;
    logic [1:0] alu_op, c_rs, c_rt;
    logic stall, busy;
    logic [3:0] o_ctrl;
    logic [4:0] wreg;
    logic [31:0] wdata, res;
    logic [5:0] rfn [16];
    logic [31:0] md_a [8];
    logic [31:0] md_b [8];
    logic [5:0] md_f [8];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    execute_muldiv #(.NB_DATA(N), .NB_REG(5), .NB_SH(5)) dut (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_RA(ra), .i_RB(rb),
        .i_inmediato(imm), .i_rt(rt), .i_rd(rd), .i_funct(funct), .i_opcode(opcode),
        .i_shamt(shamt), .i_ctrl(ctrl), .i_EX_alu_src(alu_src), .i_EX_reg_dst(reg_dst),
        .i_EX_alu_op(alu_op), .i_corto_rs(c_rs), .i_corto_rt(c_rt),
        .i_input_ALU_MEM(fw_mem), .i_output_WB(fw_wb), .o_stall(stall), .o_busy(busy),
        .o_ctrl(o_ctrl), .o_write_reg(wreg), .o_data_to_write_in_MEM(wdata), .o_ALU_result(res)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        valid = 0; ra = 0; rb = 0; imm = 0; fw_mem = 0; fw_wb = 0; rt = 0; rd = 0; shamt = 0;
        funct = 0; opcode = 0; ctrl = 0; alu_src = 0; reg_dst = 0; alu_op = 0; c_rs = 0; c_rt = 0;
    endtask

    task automatic rtype(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        bubble();
        valid = 1; alu_op = 2'b10; funct = fn; ra = a; rb = b; rd = 5'd9; rt = 5'd4; reg_dst = 1; ctrl = 4'b1000;
    endtask

    function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] rf, input logic [31:0] wb, input logic [31:0] mem);
        return s == 0 ? rf : s == 1 ? wb : s == 2 ? mem : 32'd0;
    endfunction

    function automatic logic [31:0] alu_model(input logic [1:0] op, input logic [5:0] fn, input logic [5:0] opc,
                                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] im, input logic [4:0] sh);
        int sa, sb;
        logic [4:0] vs;
        sa = a; sb = b; vs = b[4:0];
        if (op == 2'b00) return a + b;
        if (op == 2'b10) begin
            case (fn)
                6'h00: return b << sh;
                6'h02: return b >> sh;
                6'h03: return sb >>> sh;
                6'h04: return a << vs;
                6'h06: return a >> vs;
                6'h07: return sa >>> vs;
                6'h20, 6'h21: return a + b;
                6'h22, 6'h23: return a - b;
                6'h24: return a & b;
                6'h25: return a | b;
                6'h26: return a ^ b;
                6'h27: return ~(a | b);
                6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
                6'h2B: return (a < b) ? 32'd1 : 32'd0;
                default: return 32'd0;
            endcase
        end
        if (op == 2'b11) begin
            case (opc)
                6'h08, 6'h09: return a + b;
                6'h0A: return (sa < sb) ? 32'd1 : 32'd0;
                6'h0B: return (a < b) ? 32'd1 : 32'd0;
                6'h0C: return a & b;
                6'h0D: return a | b;
                6'h0E: return a ^ b;
                6'h0F: return im * 32'h10000;
                default: return 32'd0;
            endcase
        end
        return 32'd0;
    endfunction

    task automatic md_model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] hi, output logic [31:0] lo);
        longint p;
        logic [63:0] up;
        int sa, sb;
        sa = a; sb = b;
        if (fn == 6'h18) begin
            p = longint'(sa) * longint'(sb);
            hi = p[63:32]; lo = p[31:0];
        end else if (fn == 6'h19) begin
            up = {32'd0, a} * {32'd0, b};
            hi = up[63:32]; lo = up[31:0];
        end else if (b == 0) begin
            hi = a; lo = 32'hFFFF_FFFF;
        end else if (fn == 6'h1A) begin
            if (a == MIN && b == 32'hFFFF_FFFF) begin
                lo = MIN; hi = 0;
            end else begin
                lo = sa / sb; hi = sa % sb;
            end
        end else begin
            lo = a / b; hi = a % b;
        end
    endtask

    task automatic md_run(input string tag, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        int n;
        md_model(fn, a, b, eh, el);
        rtype(fn, a, b);
        tick();
        bubble();
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk({tag, "_busy_cycles"}, 32'(n), 32'd33);
        rtype(6'h10, 0, 0);
        tick();
        chk({tag, "_hi"}, res, eh);
        rtype(6'h12, 0, 0);
        tick();
        chk({tag, "_lo"}, res, el);
    endtask

    initial begin
        int n, bad;
        rfn = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
        rst = 1;
        rtype(6'h20, 32'd5, 32'd6);
        tick();
        tick();
        chk("rst_res", res, 0);
        chk("rst_data", wdata, 0);
        chk("rst_wreg", 32'(wreg), 0);
        chk("rst_ctrl", 32'(o_ctrl), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 0;
        rtype(6'h10, 0, 0);
        #1;
        chk("rst_stall", 32'(stall), 0);
        tick();
        chk("rst_hi", res, 0);

        bubble();
        valid = 1; alu_op = 2'b10; funct = 6'h20; c_rs = 2'b10; fw_mem = 7; ra = 99; rb = 5;
        rd = 5'd17; rt = 5'd3; reg_dst = 1; ctrl = 4'b1010;
        tick();
        chk("fwd_add_res", res, 12);
        chk("fwd_add_data", wdata, 5);
        chk("fwd_add_wreg", 32'(wreg), 17);
        chk("fwd_add_ctrl", 32'(o_ctrl), 4'b1010);
        bubble();
        valid = 1; alu_op = 2'b11; opcode = 6'h08; alu_src = 1; imm = 32'hFFFF_FFFF; ra = 10; rb = 77;
        rt = 5'd6; rd = 5'd20; reg_dst = 0; ctrl = 4'b1000;
        tick();
        chk("addi_res", res, 9);
        chk("addi_wreg", 32'(wreg), 6);
        chk("addi_data", wdata, 77);

        for (int k = 0; k < 40; k++) begin
            int s;
            logic [31:0] av, tv, bv, ex;
            s = $urandom_range(0, 26);
            bubble();
            valid = 1;
            ra = $urandom; rb = $urandom; fw_mem = $urandom; fw_wb = $urandom; imm = $urandom;
            if (k % 3 == 0) begin
                ra = $urandom_range(0, 20) - 32'd10;
                rb = $urandom_range(0, 20) - 32'd10;
            end
            shamt = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); reg_dst = 1'($urandom);
            ctrl = 4'($urandom); c_rs = 2'($urandom); c_rt = 2'($urandom);
            if (s < 16) begin
                alu_op = 2'b10; funct = rfn[s];
            end else if (s < 24) begin
                alu_op = 2'b11; opcode = 6'(s - 8); alu_src = 1;
            end else if (s == 24) begin
                alu_op = 2'b00; alu_src = 1'($urandom);
            end else if (s == 25) begin
                alu_op = 2'b01;
            end else begin
                alu_op = 2'b10; funct = 6'h3F;
            end
            av = pick(c_rs, ra, fw_wb, fw_mem);
            tv = pick(c_rt, rb, fw_wb, fw_mem);
            bv = alu_src ? imm : tv;
            ex = alu_model(alu_op, funct, opcode, av, bv, imm, shamt);
            tick();
            chk($sformatf("rnd%0d_res", k), res, ex);
            chk($sformatf("rnd%0d_wreg", k), 32'(wreg), 32'(reg_dst ? rd : rt));
            chk($sformatf("rnd%0d_data", k), wdata, tv);
            chk($sformatf("rnd%0d_ctrl", k), 32'(o_ctrl), 32'(ctrl));
        end

        rtype(6'h18, 32'hFFFF_FFFD, 32'd4);
        ctrl = 4'b1100;
        tick();
        rtype(6'h12, 0, 0);
        #1;
        n = 0;
        bad = 0;
        while (stall === 1'b1 && n < 100) begin
            n++;
            tick();
            if (o_ctrl !== 0 || res !== 0 || wreg !== 0) bad++;
        end
        chk("mult_stall_cycles", 32'(n), 33);
        chk("mult_stall_bubbles", 32'(bad), 0);
        tick();
        chk("mult_mflo", res, 32'hFFFF_FFF4);
        rtype(6'h10, 0, 0);
        tick();
        chk("mult_mfhi", res, 32'hFFFF_FFFF);

        md_run("div_m7_2", 6'h1A, 32'hFFFF_FFF9, 32'd2);
        md_run("divu_9_0", 6'h1B, 32'd9, 32'd0);
        md_run("div_min_m1", 6'h1A, MIN, 32'hFFFF_FFFF);
        md_run("div_m9_0", 6'h1A, 32'hFFFF_FFF7, 32'd0);
        md_run("mult_min_min", 6'h18, MIN, MIN);
        md_run("multu_max", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        md_run("div_7_m2", 6'h1A, 32'd7, 32'hFFFF_FFFE);
        md_run("divu_max_3", 6'h1B, 32'hFFFF_FFFF, 32'd3);
        for (int k = 0; k < 8; k++) begin
            md_f[k] = 6'h18 + 6'($urandom_range(0, 3));
            md_a[k] = $urandom;
            md_b[k] = (k % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
            md_run($sformatf("md_rnd%0d", k), md_f[k], md_a[k], md_b[k]);
        end

        rtype(6'h11, 32'h0000_A5A5, 0);
        tick();
        rtype(6'h13, 32'h0000_5A5A, 0);
        tick();
        rtype(6'h10, 0, 0);
        tick();
        chk("mthi", res, 32'h0000_A5A5);
        rtype(6'h12, 0, 0);
        tick();
        chk("mtlo", res, 32'h0000_5A5A);
        rtype(6'h18, 32'd3, 32'd5);
        valid = 0;
        tick();
        chk("inv_mult_busy", 32'(busy), 0);
        chk("inv_mult_ctrl", 32'(o_ctrl), 0);
        rtype(6'h11, 32'h1234, 0);
        valid = 0;
        tick();
        rtype(6'h10, 0, 0);
        tick();
        chk("inv_hi_kept", res, 32'h0000_A5A5);

        rtype(6'h19, 32'd6, 32'd7);
        tick();
        rtype(6'h20, 32'd100, 32'd23);
        rd = 5'd12;
        #1;
        chk("busy_add_stall", 32'(stall), 0);
        tick();
        chk("busy_add_res", res, 123);
        chk("busy_add_wreg", 32'(wreg), 12);
        chk("busy_add_busy", 32'(busy), 1);
        bubble();
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk("multu_remaining_busy", 32'(n), 32);
        rtype(6'h12, 0, 0);
        tick();
        chk("multu_lo", res, 42);

        rtype(6'h11, 32'hDEAD, 0);
        tick();
        rtype(6'h1A, 32'd100, 32'd7);
        tick();
        bubble();
        repeat (9) tick();
        chk("pre_rst_busy", 32'(busy), 1);
        rst = 1;
        tick();
        rst = 0;
        rtype(6'h10, 0, 0);
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_stall", 32'(stall), 0);
        tick();
        chk("mid_rst_mfhi", res, 0);
        bubble();
        repeat (40) tick();
        rtype(6'h12, 0, 0);
        tick();
        chk("mid_rst_mflo", res, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
